// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The optional FETCH_BOUND_EN build option is handled in pc_next_gen.
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_pc_next_gen.sv
// Next-PC selection: redirect target (word aligned) > sequential step > hold.
// With FETCH_BOUND_EN defined, a sequential step past BOUND_HI wraps to BOUND_LO.
module pc_next_gen
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] BOUND_LO = 32'h0000_000C,
   parameter logic [31:0] BOUND_HI = 32'h0000_0023
) (
   input  logic        advance,
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_next,
   output logic        misalign
);

   logic [31:0] pc_inc;
   logic [31:0] pc_seq;

   assign pc_inc = pc + 32'(INSTR_BYTES);

`ifdef FETCH_BOUND_EN
   assign pc_seq = (pc_inc > BOUND_HI) ? BOUND_LO : pc_inc;
`else
   logic bound_unused;
   assign bound_unused = ^{BOUND_LO, BOUND_HI};
   assign pc_seq       = pc_inc;
`endif

   always_comb begin
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = {redirect_pc[31:2], 2'b00};
      end else if (advance) begin
         pc_next = pc_seq;
      end
   end

   assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding imem read, valid/ready to decode,
// stall and redirect from execute. Build option FETCH_BOUND_EN bounds the sequential PC.
module fetch_sequencer
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BOUND_LO = 32'h0000_000C,
   parameter logic [31:0] BOUND_HI = 32'h0000_0023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_instr_o,
   input  logic        if_ready_i,
   output logic        misalign_o
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  req_pc;
   logic         kill;
   logic         advance;
   logic         capture;
   logic         redirect_misalign;

   assign advance = (state == REQ) && imem_gnt_i;
   // A redirect arriving together with rvalid squashes that response as well.
   assign capture = (state == WAIT) && imem_rvalid_i && !kill && !redirect_valid_i;

   pc_next_gen #(
      .BOUND_LO (BOUND_LO),
      .BOUND_HI (BOUND_HI)
   ) u_pc_next (
      .advance        (advance),
      .pc             (pc),
      .redirect_valid (redirect_valid_i),
      .redirect_pc    (redirect_pc_i),
      .pc_next        (pc_next),
      .misalign       (redirect_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (!stall_i) state_next = REQ;
         REQ:  if (imem_gnt_i) state_next = WAIT;
         WAIT: if (imem_rvalid_i) state_next = capture ? HOLD : IDLE;
         HOLD: begin
            if (redirect_valid_i) begin
               state_next = IDLE;
            end else if (if_ready_i) begin
               state_next = stall_i ? IDLE : REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      imem_req_o  = (state == REQ);
      if_valid_o  = (state == HOLD);
      imem_addr_o = pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         req_pc     <= RESET_PC;
         kill       <= 1'b0;
         misalign_o <= 1'b0;
         if_pc_o    <= 32'h0;
         if_instr_o <= 32'h0;
      end else begin
         pc         <= pc_next;
         misalign_o <= redirect_misalign;
         if (advance) begin
            req_pc <= pc;
         end
         if ((state == WAIT) && imem_rvalid_i) begin
            kill <= 1'b0;
         end else if (redirect_valid_i && (advance || (state == WAIT))) begin
            kill <= 1'b1;
         end
         if (capture) begin
            if_pc_o    <= req_pc;
            if_instr_o <= imem_rdata_i;
         end
      end
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences it against a single-port instruction memory with a req/gnt/rvalid handshake. It supplies fetched instructions to decode over a valid/ready interface. It also applies stall and branch/jump redirects from the execute stage. At most one memory transaction is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
BOUND_LO, 32'h0000_000C, wrap-target address (used only with FETCH_BOUND_EN).
BOUND_HI, 32'h0000_0023, highest PC fetched before wrapping (used only with FETCH_BOUND_EN).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC, issue no new request
redirect_valid_i  in  1  branch/jump taken this cycle
redirect_pc_i  in  32  redirect target
imem_req_o  out  1  memory request
imem_addr_o  out  32  request address, stable while req high
imem_gnt_i  in  1  request accepted
imem_rvalid_i  in  1  read data valid (≥1 cycle after gnt)
imem_rdata_i  in  32  read data
if_valid_o  out  1  instruction valid to decode
if_pc_o  out  32  PC of if_instr_o
if_instr_o  out  32  fetched instruction
if_ready_i  in  1  decode accepts
misalign_o  out  1  one-cycle pulse: redirect target[1:0]!=0

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; state=IDLE; imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0, misalign_o=0, kill=0. rst overrides every other input, mid-transaction included; a late rvalid for the pre-reset request is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: if !stall_i -> REQ next cycle. Reset-to-first-req latency: 1 cycle.
- REQ: imem_req_o=1, imem_addr_o=pc. On gnt -> WAIT; pc_next=pc+4 (mod 2^32). Without gnt, stay in REQ; req stays high and addr stays stable (no retraction, even on stall).
- WAIT: on rvalid, if kill=0 -> latch {pc_of_req, rdata} and go to HOLD; if kill=1 -> drop the data, clear kill, go to IDLE.
- HOLD: if_valid_o=1. When if_valid_o&&if_ready_i: if !stall_i, go straight to REQ (back-to-back fetch) else IDLE. if_pc_o and if_instr_o are stable while valid && !ready.
- Throughput: 1 instr per 3 cycles with 1-cycle memory latency (REQ, WAIT, HOLD).
- Redirect, priority over sequential increment:
  - pc <= {redirect_pc_i[31:2],2'b00}; misalign_o pulses next cycle if redirect_pc_i[1:0]!=0.
  - In REQ without gnt: address replaced next cycle (only allowed req-address change).
  - In REQ with gnt same cycle, or in WAIT: kill=1 so the in-flight response is discarded.
  - In HOLD: if_valid_o drops next cycle; the held instruction is never presented again; -> IDLE.
  - In IDLE: next request uses the target.
  - Redirect and if_ready_i in the same cycle: redirect wins; the instruction counts as consumed.
- stall_i does not block redirect or the rvalid capture.
- Wrap-around: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.

Optional Feature:
FETCH_BOUND_EN: when defined, a sequential PC increment whose result would exceed BOUND_HI loads BOUND_LO instead (fixed test-loop window). Redirects are not bounded. When undefined: plain +4, BOUND_* unused.

Decomposition:
- Package riscv_fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD), INSTR_BYTES=4, NOP constant 32'h0000_0013.
- Sub-module pc_next_gen (combinational): takes pc, redirect, gnt, bound params; returns next PC and the misalign flag. The sequencer FSM stays in fetch_sequencer.

Test Plan:
1. Reset release, gnt same-cycle, rvalid next cycle, ready=1 -> addresses 0x0,0x4,0x8 issued; if_pc_o=0x0,0x4,0x8 with matching rdata.
2. gnt held low 3 cycles at pc=0x8 -> req=1 and addr=0x8 constant for 4 cycles; no PC advance.
3. Redirect to 0x40 while in WAIT for 0x4 -> rvalid data for 0x4 never presented; next request addr=0x40; next if_pc_o=0x40.
4. HOLD with if_ready_i=0 for 5 cycles -> if_valid_o/if_pc_o/if_instr_o stable; no new req until ready.
5. Redirect to 0x42 -> misalign_o pulses once; fetch addr=0x40.
6. FETCH_BOUND_EN, sequential run from 0x0 -> addresses 0x0..0x20 then 0xC; the same run without the macro gives 0x24.
